// File: rtl/icache_fetch_rob_pkg.sv
// Shared types for the fetch-side reorder buffer in front of the icache upstream port.
package icache_fetch_rob_pkg;

  localparam int ADDR_WIDTH                 = 32;
  localparam int ICACHE_UPSTREAM_DATA_WIDTH = 32;
  localparam int ICACHE_REQ_TXNID_WIDTH     = 4;
  localparam int ROB_ENTRY_NUM              = 8;

  typedef logic [ADDR_WIDTH-1:0] req_addr_t;

  localparam logic [1:0] UPSTREAM_OPCODE = 2'b01;

  typedef struct packed {
    req_addr_t                         addr;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
    logic [1:0]                        opcode;
  } pc_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    DONE   = 2'd2,
    ZOMBIE = 2'd3
  } rob_state_e;

  typedef struct packed {
    req_addr_t                             addr;
    logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/icache_fetch_rob_if.sv
// Request/response bundle between the fetch ROB (master) and the icache upstream port (slave).
interface icache_fetch_rob_if;
  import icache_fetch_rob_pkg::*;

  logic                                  icache_req_vld;
  logic                                  icache_req_rdy;
  pc_req_t                               icache_req_pld;
  logic                                  icache_rsp_vld;
  logic [ICACHE_REQ_TXNID_WIDTH-1:0]     icache_rsp_txnid;
  logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0] icache_rsp_data;

  modport master (
    output icache_req_vld, icache_req_pld,
    input  icache_req_rdy, icache_rsp_vld, icache_rsp_txnid, icache_rsp_data
  );

  modport slave (
    input  icache_req_vld, icache_req_pld,
    output icache_req_rdy, icache_rsp_vld, icache_rsp_txnid, icache_rsp_data
  );

endinterface

// File: rtl/icache_fetch_rob_entry.sv
// One ROB slot: IDLE/PEND/DONE/ZOMBIE lifecycle plus the fetch address and returned data.
module icache_fetch_rob_entry
  import icache_fetch_rob_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  alloc,
  input  req_addr_t                             alloc_addr,
  input  logic                                  rsp_hit,
  input  logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0] rsp_data,
  input  logic                                  drain,
  input  logic                                  flush,
  output rob_state_e                            state,
  output logic                                  busy_nxt,
  output rob_entry_t                            ent
);

  rob_state_e state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A response landing on a PEND slot during a flush is dropped outright instead of parking as ZOMBIE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (alloc) state_nxt = PEND;
      PEND:    if (flush) state_nxt = rsp_hit ? IDLE : ZOMBIE;
               else if (rsp_hit) state_nxt = DONE;
      DONE:    if (flush || drain) state_nxt = IDLE;
      ZOMBIE:  if (rsp_hit) state_nxt = IDLE;
      default: state_nxt = state;
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE);

  always_ff @(posedge clk) begin
    if (alloc) ent.addr <= alloc_addr;
    if (rsp_hit && state == PEND && !flush) ent.data <= rsp_data;
  end

  rsp_to_live_slot: assert property (@(posedge clk) disable iff (rst)
    rsp_hit |-> (state == PEND || state == ZOMBIE));

endmodule

// File: rtl/icache_fetch_rob.sv
// Fetch reorder buffer: issues BPU fetches to the icache with txnid = slot index and
// returns the (possibly out-of-order) responses to the fetch queue in program order.
module icache_fetch_rob
  import icache_fetch_rob_pkg::*;
#(
  parameter int ENTRY_NUM   = ROB_ENTRY_NUM,
  parameter int DATA_WIDTH  = ICACHE_UPSTREAM_DATA_WIDTH,
  parameter int TXNID_WIDTH = ICACHE_REQ_TXNID_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bpu_req_vld,
  output logic                        bpu_req_rdy,
  input  req_addr_t                   bpu_req_addr,
  input  logic                        flush,
  icache_fetch_rob_if.master          ic,
  output logic                        fetch_out_vld,
  input  logic                        fetch_out_rdy,
  output logic [DATA_WIDTH-1:0]       fetch_out_data,
  output req_addr_t                   fetch_out_addr,
  output logic [$clog2(ENTRY_NUM):0]  occupancy
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int OCC_W = IDX_W + 1;

  logic [IDX_W-1:0]       head, tail;
  logic                   req_vld;
  pc_req_t                req_pld;
  logic                   alloc, drain;
  logic [TXNID_WIDTH-1:0] rsp_txnid;
  logic [IDX_W-1:0]       rsp_idx;
  logic [OCC_W-1:0]       occ_nxt;
  logic [ENTRY_NUM-1:0]   busy_nxt;
  rob_state_e             state_arr [ENTRY_NUM];
  rob_entry_t             ent_arr   [ENTRY_NUM];

  assign rsp_txnid = ic.icache_rsp_txnid;
  assign rsp_idx   = rsp_txnid[IDX_W-1:0];

  // Allocation looks only at registered slot state, so a slot freed this cycle is reused next cycle.
  assign bpu_req_rdy = !flush && (state_arr[tail] == IDLE) && (!req_vld || ic.icache_req_rdy);
  assign alloc       = bpu_req_vld && bpu_req_rdy;

  assign fetch_out_vld  = !flush && (state_arr[head] == DONE);
  assign drain          = fetch_out_vld && fetch_out_rdy;
  assign fetch_out_data = ent_arr[head].data;
  assign fetch_out_addr = ent_arr[head].addr;

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_ent
    icache_fetch_rob_entry u_ent (
      .clk        (clk),
      .rst        (rst),
      .alloc      (alloc && tail == IDX_W'(i)),
      .alloc_addr (bpu_req_addr),
      .rsp_hit    (ic.icache_rsp_vld && rsp_idx == IDX_W'(i)),
      .rsp_data   (ic.icache_rsp_data),
      .drain      (drain && head == IDX_W'(i)),
      .flush      (flush),
      .state      (state_arr[i]),
      .busy_nxt   (busy_nxt[i]),
      .ent        (ent_arr[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= tail;
    end else begin
      if (drain) head <= head + IDX_W'(1);
      if (alloc) tail <= tail + IDX_W'(1);
    end
  end

  // A presented request is never withdrawn, even across a flush; its slot simply turns ZOMBIE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    req_vld <= 1'b0;
    else if (alloc)             req_vld <= 1'b1;
    else if (ic.icache_req_rdy) req_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (alloc) req_pld <= '{addr: bpu_req_addr, txnid: ICACHE_REQ_TXNID_WIDTH'(tail), opcode: UPSTREAM_OPCODE};
  end

  assign ic.icache_req_vld = req_vld;
  assign ic.icache_req_pld = req_pld;

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < ENTRY_NUM; i++) occ_nxt = occ_nxt + OCC_W'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occupancy <= '0;
    else     occupancy <= occ_nxt;
  end

  rsp_txnid_upper_zero: assert property (@(posedge clk) disable iff (rst)
    ic.icache_rsp_vld |-> ((rsp_txnid >> IDX_W) == '0));

endmodule

// File: tb/tb_icache_fetch_rob.sv
// Directed bench for icache_fetch_rob with a program-order queue model checked every cycle.
module tb_icache_fetch_rob;
  import icache_fetch_rob_pkg::*;

  localparam int N = ROB_ENTRY_NUM;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bpu_req_vld = 1'b0;
  logic        bpu_req_rdy;
  req_addr_t   bpu_req_addr = '0;
  logic        flush = 1'b0;
  logic        fetch_out_vld;
  logic        fetch_out_rdy = 1'b1;
  logic [31:0] fetch_out_data;
  req_addr_t   fetch_out_addr;
  logic [3:0]  occupancy;

  icache_fetch_rob_if ic();

  always #5 clk = ~clk;

  icache_fetch_rob dut (
    .clk            (clk),
    .rst            (rst),
    .bpu_req_vld    (bpu_req_vld),
    .bpu_req_rdy    (bpu_req_rdy),
    .bpu_req_addr   (bpu_req_addr),
    .flush          (flush),
    .ic             (ic),
    .fetch_out_vld  (fetch_out_vld),
    .fetch_out_rdy  (fetch_out_rdy),
    .fetch_out_data (fetch_out_data),
    .fetch_out_addr (fetch_out_addr),
    .occupancy      (occupancy)
  );

  // Model: fetches not yet delivered, in program order, plus the set of txnids whose
  // responses must still be swallowed after a flush.
  typedef struct {
    req_addr_t   addr;
    int          txn;
    bit          has;
    logic [31:0] data;
  } rec_t;

  rec_t      live[$];
  bit        zmb [N];
  int        tl;
  bit        mq_vld;
  req_addr_t mq_addr;
  int        mq_txn;
  int        alloc_cnt = 0;
  int        n_cmp = 0;
  int        n_err = 0;

  function automatic logic [31:0] dat(req_addr_t a);
    return a ^ 32'hD00D_0000;
  endfunction

  function automatic bit m_free(int t);
    if (zmb[t]) return 1'b0;
    foreach (live[i]) if (live[i].txn == t) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_rdy();
    return !flush && m_free(tl) && (!mq_vld || ic.icache_req_rdy);
  endfunction

  function automatic bit m_out_vld();
    return !flush && live.size() > 0 && live[0].has;
  endfunction

  function automatic int m_occ();
    int c = live.size();
    for (int t = 0; t < N; t++) c += int'(zmb[t]);
    return c;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    live.delete();
    for (int t = 0; t < N; t++) zmb[t] = 1'b0;
    tl     = 0;
    mq_vld = 1'b0;
  endtask

  task automatic model_update();
    bit a;
    bit d;
    int t;
    a = bpu_req_vld && m_rdy();
    d = m_out_vld() && fetch_out_rdy;
    if (ic.icache_rsp_vld) begin
      t = int'(ic.icache_rsp_txnid) % N;
      if (zmb[t]) begin
        zmb[t] = 1'b0;
      end else begin
        foreach (live[i]) begin
          if (live[i].txn == t && !live[i].has) begin
            live[i].has  = 1'b1;
            live[i].data = ic.icache_rsp_data;
          end
        end
      end
    end
    if (flush) begin
      foreach (live[i]) begin
        if (!live[i].has) zmb[live[i].txn] = 1'b1;
      end
      live.delete();
    end else begin
      if (d) void'(live.pop_front());
      if (a) live.push_back('{addr: bpu_req_addr, txn: tl, has: 1'b0, data: '0});
    end
    if (a) begin
      mq_vld  = 1'b1;
      mq_addr = bpu_req_addr;
      mq_txn  = tl;
      tl      = (tl + 1) % N;
      alloc_cnt++;
    end else if (ic.icache_req_rdy) begin
      mq_vld = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  task automatic push(req_addr_t a);
    int c0 = alloc_cnt;
    bpu_req_vld  = 1'b1;
    bpu_req_addr = a;
    for (int k = 0; k < 20 && alloc_cnt == c0; k++) step();
    bpu_req_vld = 1'b0;
    chk("push_accepted", 64'(alloc_cnt != c0), 64'd1);
  endtask

  task automatic rsp(int t, logic [31:0] d);
    ic.icache_rsp_vld   = 1'b1;
    ic.icache_rsp_txnid = 4'(t);
    ic.icache_rsp_data  = d;
    step();
    ic.icache_rsp_vld   = 1'b0;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bpu_req_vld        = 1'b0;
    flush              = 1'b0;
    ic.icache_rsp_vld  = 1'b0;
    ic.icache_req_rdy  = 1'b1;
    fetch_out_rdy      = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("bpu_req_rdy", 64'(bpu_req_rdy), 64'(m_rdy()));
        chk("icache_req_vld", 64'(ic.icache_req_vld), 64'(mq_vld));
        if (mq_vld) begin
          chk("req_addr", 64'(ic.icache_req_pld.addr), 64'(mq_addr));
          chk("req_txnid", 64'(ic.icache_req_pld.txnid), 64'(mq_txn));
          chk("req_opcode", 64'(ic.icache_req_pld.opcode), 64'(UPSTREAM_OPCODE));
        end
        chk("fetch_out_vld", 64'(fetch_out_vld), 64'(m_out_vld()));
        if (m_out_vld()) begin
          chk("fetch_out_data", 64'(fetch_out_data), 64'(live[0].data));
          chk("fetch_out_addr", 64'(fetch_out_addr), 64'(live[0].addr));
        end
        chk("occupancy", 64'(occupancy), 64'(m_occ()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ic.icache_req_rdy   = 1'b1;
    ic.icache_rsp_vld   = 1'b0;
    ic.icache_rsp_txnid = '0;
    ic.icache_rsp_data  = '0;
    do_reset();
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_req_vld", 64'(ic.icache_req_vld), 64'd0);
    chk("rst_out_vld", 64'(fetch_out_vld), 64'd0);

    // In-order returns
    push(32'h100); chk("io_txn0", 64'(ic.icache_req_pld.txnid), 64'd0);
    chk("io_req_vld", 64'(ic.icache_req_vld), 64'd1);
    push(32'h140); chk("io_txn1", 64'(ic.icache_req_pld.txnid), 64'd1);
    push(32'h180); chk("io_txn2", 64'(ic.icache_req_pld.txnid), 64'd2);
    rsp(0, dat(32'h100));
    chk("io_vld0", 64'(fetch_out_vld), 64'd1);
    chk("io_data0", 64'(fetch_out_data), 64'hD00D_0100);
    chk("io_addr0", 64'(fetch_out_addr), 64'h100);
    rsp(1, dat(32'h140)); chk("io_addr1", 64'(fetch_out_addr), 64'h140);
    rsp(2, dat(32'h180)); chk("io_addr2", 64'(fetch_out_addr), 64'h180);
    step(); step();
    chk("io_occ_end", 64'(occupancy), 64'd0);

    // Out-of-order returns 3,1,0,2
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i * 'h40));
    rsp(3, dat(32'h2C0)); chk("ooo_vld_after3", 64'(fetch_out_vld), 64'd0);
    rsp(1, dat(32'h240)); chk("ooo_vld_after1", 64'(fetch_out_vld), 64'd0);
    rsp(0, dat(32'h200)); chk("ooo_vld_after0", 64'(fetch_out_vld), 64'd1);
    chk("ooo_addr0", 64'(fetch_out_addr), 64'h200);
    step(); chk("ooo_addr1", 64'(fetch_out_addr), 64'h240);
    step(); chk("ooo_gap", 64'(fetch_out_vld), 64'd0);
    rsp(2, dat(32'h280)); chk("ooo_addr2", 64'(fetch_out_addr), 64'h280);
    step(); chk("ooo_addr3", 64'(fetch_out_addr), 64'h2C0);
    chk("ooo_data3", 64'(fetch_out_data), 64'hD00D_02C0);
    step(); step();
    chk("ooo_occ_end", 64'(occupancy), 64'd0);

    // Full and request backpressure
    do_reset();
    ic.icache_req_rdy = 1'b0;
    push(32'h600); chk("bp_txn0", 64'(ic.icache_req_pld.txnid), 64'd0);
    bpu_req_vld  = 1'b1;
    bpu_req_addr = 32'h640;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_rdy", 64'(bpu_req_rdy), 64'd0);
      chk("bp_hold_addr", 64'(ic.icache_req_pld.addr), 64'h600);
      chk("bp_hold_vld", 64'(ic.icache_req_vld), 64'd1);
    end
    ic.icache_req_rdy = 1'b1;
    for (int i = 1; i < 8; i++) push(32'h600 + 32'(i * 'h40));
    chk("full_rdy", 64'(bpu_req_rdy), 64'd0);
    chk("full_occ", 64'(occupancy), 64'd8);
    bpu_req_vld = 1'b1; bpu_req_addr = 32'h800;
    step(); step();
    chk("full_rdy_hold", 64'(bpu_req_rdy), 64'd0);
    chk("full_occ_hold", 64'(occupancy), 64'd8);
    bpu_req_vld = 1'b0;
    for (int t = 7; t >= 0; t--) rsp(t, dat(32'h600 + 32'(t * 'h40)));
    chk("full_first_out", 64'(fetch_out_addr), 64'h600);
    repeat (10) step();
    chk("full_occ_end", 64'(occupancy), 64'd0);

    // Flush with two DONE and two PEND entries
    do_reset();
    fetch_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(i * 'h40));
    rsp(0, dat(32'h300));
    rsp(1, dat(32'h340));
    chk("fl_pre_occ", 64'(occupancy), 64'd4);
    chk("fl_pre_vld", 64'(fetch_out_vld), 64'd1);
    flush = 1'b1; #1;
    chk("fl_vld_during", 64'(fetch_out_vld), 64'd0);
    chk("fl_rdy_during", 64'(bpu_req_rdy), 64'd0);
    step(); flush = 1'b0; #1;
    chk("fl_vld_after", 64'(fetch_out_vld), 64'd0);
    chk("fl_occ_zombies", 64'(occupancy), 64'd2);
    fetch_out_rdy = 1'b1;
    push(32'h400); chk("fl_new_txn", 64'(ic.icache_req_pld.txnid), 64'd4);
    chk("fl_occ_new", 64'(occupancy), 64'd3);
    rsp(2, dat(32'h380)); chk("fl_drop2", 64'(fetch_out_vld), 64'd0);
    rsp(3, dat(32'h3C0)); chk("fl_drop3", 64'(fetch_out_vld), 64'd0);
    rsp(4, dat(32'h400));
    chk("fl_out_vld", 64'(fetch_out_vld), 64'd1);
    chk("fl_out_addr", 64'(fetch_out_addr), 64'h400);
    chk("fl_out_data", 64'(fetch_out_data), 64'hD00D_0400);
    step(); step();
    chk("fl_occ_end", 64'(occupancy), 64'd0);

    // ZOMBIE at tail after wraparound
    do_reset();
    push(32'h700); push(32'h740);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 6; i++) push(32'h780 + 32'(i * 'h40));
    for (int t = 2; t < 8; t++) rsp(t, dat(32'h780 + 32'((t - 2) * 'h40)));
    repeat (3) step();
    chk("zb_occ", 64'(occupancy), 64'd2);
    bpu_req_vld = 1'b1; bpu_req_addr = 32'h900;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("zb_stall0", 64'(bpu_req_rdy), 64'd0);
    end
    rsp(0, 32'hBAD0_0000);
    chk("zb_free0", 64'(bpu_req_rdy), 64'd1);
    push(32'h900); chk("zb_txn0", 64'(ic.icache_req_pld.txnid), 64'd0);
    bpu_req_vld = 1'b1; bpu_req_addr = 32'h940;
    step(); chk("zb_stall1", 64'(bpu_req_rdy), 64'd0);
    rsp(1, 32'hBAD0_0001);
    push(32'h940); chk("zb_txn1", 64'(ic.icache_req_pld.txnid), 64'd1);
    rsp(0, dat(32'h900));
    rsp(1, dat(32'h940));
    repeat (3) step();
    chk("zb_occ_end", 64'(occupancy), 64'd0);

    // Asynchronous reset with five busy entries
    do_reset();
    fetch_out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hA00 + 32'(i * 'h40));
    ic.icache_req_rdy = 1'b0;
    rsp(0, dat(32'hA00));
    chk("ar_pre_out", 64'(fetch_out_vld), 64'd1);
    chk("ar_pre_req", 64'(ic.icache_req_vld), 64'd1);
    chk("ar_pre_occ", 64'(occupancy), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("ar_req_vld", 64'(ic.icache_req_vld), 64'd0);
    chk("ar_out_vld", 64'(fetch_out_vld), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    model_reset();
    step(); step();
    rst = 1'b0;
    ic.icache_req_rdy = 1'b1;
    fetch_out_rdy = 1'b1;
    push(32'hB00); chk("ar_first_txn", 64'(ic.icache_req_pld.txnid), 64'd0);
    rsp(0, dat(32'hB00));
    step(); step();
    chk("ar_occ_end", 64'(occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_fetch_rob.md
Name: icache_fetch_rob

Overview:
- Fetch-side reorder buffer directly upstream of icache_top.
- Takes in-order fetch addresses from the BPU, allocates a txnid per fetch and issues pc_req_t requests into the icache upstream rxreq port.
- Captures icache upstream txdat responses, which may return out of order on miss/linefill, and drains them in program order to the fetch queue.
- Handles pipeline flush without losing track of in-flight txnids.

Parameters:
- ENTRY_NUM, 8, number of ROB entries; power of two, ≥2; entry index = txnid[$clog2(ENTRY_NUM)-1:0].
- DATA_WIDTH, ICACHE_UPSTREAM_DATA_WIDTH, fetch data width.
- TXNID_WIDTH, ICACHE_REQ_TXNID_WIDTH, must be ≥ $clog2(ENTRY_NUM); upper txnid bits driven 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bpu_req_vld  in  1  fetch address valid.
- bpu_req_rdy  out  1  ROB can accept.
- bpu_req_addr  in  req_addr_t  fetch address.
- flush  in  1  discard all fetches not yet delivered.
- icache_req_vld  out  1  to icache upstream_rxreq_vld.
- icache_req_rdy  in  1  from icache upstream_rxreq_rdy.
- icache_req_pld  out  pc_req_t  addr, txnid = entry index, opcode = UPSTREAM_OPCODE.
- icache_rsp_vld  in  1  from icache upstream_txdat_vld; no backpressure possible.
- icache_rsp_txnid  in  TXNID_WIDTH  returning txnid.
- icache_rsp_data  in  DATA_WIDTH  returning data.
- fetch_out_vld  out  1  in-order data valid.
- fetch_out_rdy  in  1  fetch queue accepts.
- fetch_out_data  out  DATA_WIDTH  data of head entry.
- fetch_out_addr  out  req_addr_t  address of head entry.
- occupancy  out  $clog2(ENTRY_NUM)+1  entries not IDLE.

Behaviour:
- Per-entry state: IDLE, PEND (issued, awaiting data), DONE (data held), ZOMBIE (flushed, awaiting data to drop).
- Storage per entry: addr and data.
- Pointers: tail (allocate) and head (drain), $clog2(ENTRY_NUM) bits each, natural wrap.
- Reset: all entries IDLE, head = tail = 0, icache_req_vld = 0, fetch_out_vld = 0, occupancy = 0, data/addr regs don't-care.
- Allocate:
  - bpu_req_rdy = !flush & state[tail]==IDLE & (!icache_req_vld | icache_req_rdy).
  - On handshake, state[tail] goes to PEND and addr is stored.
  - The icache request register loads {addr, txnid = tail} and icache_req_vld = 1 next cycle (1-cycle latency); tail increments.
- Issue: icache_req_vld/pld held stable until icache_req_rdy. A flush never retracts a presented request; it completes, and its entry is already ZOMBIE.
- Response:
  - Always accepted. PEND goes to DONE with data written; ZOMBIE goes to IDLE with data dropped.
  - A response to an IDLE or DONE entry is a protocol error: state unchanged, and a simulation assertion fires.
- Drain:
  - fetch_out_vld = !flush & state[head]==DONE; data and addr are read combinationally from the head entry.
  - On handshake, state[head] goes to IDLE and head increments.
  - Response-to-output latency is ≥1 cycle: data written at edge N is visible at N+1.
- Flush, effective at the edge:
  - All PEND entries become ZOMBIE and all DONE entries become IDLE.
  - head is set to tail and tail holds. No allocation or drain occurs in the flush cycle.
  - A response arriving in the flush cycle to a PEND entry makes it IDLE (dropped), not DONE.
- Allocation after flush proceeds from tail. If state[tail] is ZOMBIE, bpu_req_rdy stays 0 until that entry's response returns. ZOMBIEs never reach the output.
- Full: all entries non-IDLE, so state[tail]!=IDLE and bpu_req_rdy = 0.
- Empty: state[head]!=DONE, so fetch_out_vld = 0.
- Same-cycle cases:
  - Allocate and drain together: allowed.
  - Response to entry X and drain of head Y: independent.
  - Allocate into the entry freed by a same-cycle drain or response: not allowed; rdy uses the registered state.
- occupancy is registered and updated with all same-cycle increments and decrements. ZOMBIEs count.
- Reset mid-operation: everything returns to reset values immediately. Environment guarantees no stale icache responses after reset (the icache resets together).

Decomposition:
- toy_pack gains:
  - rob_state_e {IDLE, PEND, DONE, ZOMBIE}
  - ROB_ENTRY_NUM constant
  - rob_entry_t {addr, data}
- pc_req_t, req_addr_t and UPSTREAM_OPCODE are reused from the package.
- One sub-module: icache_fetch_rob_entry, holding the per-entry state FSM plus storage, generated ENTRY_NUM times.
- Top level keeps the pointers, the request register and the head mux.

Test Plan:
- In-order: 3 requests at addr 0x100, 0x140, 0x180 return txnid 0,1,2 in order → fetch_out at 0x100, 0x140, 0x180 with matching data; occupancy returns to 0.
- Out-of-order: txnids 0..3 issued, responses return 3,1,0,2 → outputs in order 0,1,2,3. fetch_out_vld first rises the cycle after txnid 0 returns.
- Full/backpressure: 8 requests with no responses → bpu_req_rdy = 0 and occupancy = 8. Holding icache_req_rdy = 0 keeps icache_req_pld stable.
- Flush with in-flight:
  - Setup: entries 0,1 DONE and 2,3 PEND; flush.
  - Required: fetch_out_vld = 0; new request gets txnid 4.
  - Late responses for 2,3 are dropped, never output.
- ZOMBIE stall: after wraparound tail reaches a ZOMBIE entry → bpu_req_rdy = 0 until its response arrives, then the next request uses that txnid.
- Reset mid-traffic: assert rst with 5 entries busy → all outputs 0 asynchronously. After release, the first request gets txnid 0.
